// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues word reads to instruction memory under a
// credit limit, buffers in-order responses with their PC, and hands them to decode.
// A redirect reloads the PC, clears the buffer and squashes every in-flight response.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  entry_t        mem_q [FIFO_DEPTH];

  logic [CW:0]   used;
  logic          accept, drop_now, push, pop;
  logic [31:0]   redir_pc;
  logic          unused_pc_lsb;

  // Low address bits of the redirect target are ignored: fetch is word aligned.
  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign redir_pc      = {redirect_pc[31:2], 2'b00};

  // Credit: buffered entries plus outstanding requests may never exceed the FIFO.
  // Gating with reset_n keeps the request low while reset is held.
  assign used           = {1'b0, cnt_q} + {1'b0, out_q};
  assign imem_req_valid = reset_n && (used < (CW+1)'(FIFO_DEPTH)) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response is either squashed (stale epoch or redirect this cycle) or buffered.
  assign drop_now = imem_rsp_valid && (drop_q != '0);
  assign push     = imem_rsp_valid && !drop_now && !redirect_valid;

  assign inst_valid    = (cnt_q != '0);
  assign pop           = inst_valid && inst_ready;
  assign inst_data     = mem_q[rd_ptr_q].data;
  assign inst_pc       = mem_q[rd_ptr_q].pc;
  assign inst_pc_plus4 = inst_pc + 32'd4;

  // Next-state for PCs, counters and FIFO pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q + CW'(accept) - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push)   rsp_pc_d   = rsp_pc_q + 32'd4;
    if (drop_now) drop_d = drop_q - 1'b1;
    if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      drop_d     = out_d;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  // State registers; the buffer storage is cleared so the head reads zero after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) mem_q[wr_ptr_q] <= '{data: imem_rsp_data, pc: rsp_pc_q};
    end
  end

  // The credit scheme must make a push into a full buffer impossible.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && (cnt_q == CW'(FIFO_DEPTH)) && !pop));

  // Counters are bounded by the buffer depth.
  a_cnt_bound: assert property (@(posedge clock) disable iff (!reset_n)
    (out_q <= CW'(FIFO_DEPTH)) && (drop_q <= out_q));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios against a queue-based model of the fetch stage,
// checked every cycle, plus literal expectations on the observed fetch/issue streams.
module tb_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  logic        rsp_en;
  int          checks;
  int          errors;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_pc_plus4 (inst_pc_plus4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Observed streams (accepted request addresses, issued PCs and PC+4) for literal checks.
  logic [31:0] log_acc[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_p4[$];

  function automatic logic [31:0] lg(input int which, input int idx);
    case (which)
      0:       return (idx < log_acc.size()) ? log_acc[idx] : 32'hBAD0_BAD0;
      1:       return (idx < log_pc.size())  ? log_pc[idx]  : 32'hBAD0_BAD0;
      default: return (idx < log_p4.size())  ? log_p4[idx]  : 32'hBAD0_BAD0;
    endcase
  endfunction

  task automatic clear_logs();
    log_acc.delete();
    log_pc.delete();
    log_p4.delete();
  endtask

  // Instruction memory: in-order, one response per cycle when enabled, >= 1 cycle latency.
  logic [31:0] mq[$];
  logic        m_acc;
  logic [31:0] m_addr;
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clock);
      m_acc  = reset_n && imem_req_valid && imem_req_ready;
      m_addr = imem_req_addr;
      @(posedge clock);
      #1;
      if (!reset_n) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
      end else begin
        if (m_acc) mq.push_back(m_addr);
        if (rsp_en && mq.size() > 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memf(mq.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
        end
      end
    end
  end

  // Model: fetch PC, queue of in-flight requests (stale flag), queue of buffered instructions.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic [31:0] m_fetch;
  logic [31:0] m_rsp;
  bit          inflight[$];
  ent_t        fifo[$];
  ent_t        e;
  int          occ;
  logic        exp_rv;
  bit          st;

  // Compare DUT against the model, then advance the model across the coming edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst_data", inst_data, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      m_fetch = 32'h0;
      m_rsp   = 32'h0;
      inflight.delete();
      fifo.delete();
    end else begin
      occ    = fifo.size() + inflight.size();
      exp_rv = (occ < 4) && !redirect_valid;
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, m_fetch);
      chk("inst_valid", 32'(inst_valid), 32'(fifo.size() != 0));
      if (fifo.size() != 0) begin
        chk("inst_pc", inst_pc, fifo[0].pc);
        chk("inst_data", inst_data, fifo[0].data);
        chk("inst_pc_plus4", inst_pc_plus4, fifo[0].pc + 32'd4);
        if (inst_ready) begin
          log_pc.push_back(inst_pc);
          log_p4.push_back(inst_pc_plus4);
          void'(fifo.pop_front());
        end
      end
      if (imem_rsp_valid) begin
        if (inflight.size() == 0) begin
          chk("rsp_without_req", 32'd1, 32'd0);
        end else begin
          st = inflight.pop_front();
          if (!st && !redirect_valid) begin
            e.pc   = m_rsp;
            e.data = imem_rsp_data;
            fifo.push_back(e);
            m_rsp = m_rsp + 32'd4;
          end
        end
      end
      if (exp_rv && imem_req_ready) begin
        inflight.push_back(1'b0);
        log_acc.push_back(imem_req_addr);
        m_fetch = m_fetch + 32'd4;
      end
      if (redirect_valid) begin
        fifo.delete();
        foreach (inflight[i]) inflight[i] = 1'b1;
        m_fetch = {redirect_pc[31:2], 2'b00};
        m_rsp   = m_fetch;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  int n0;

  initial begin
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    rsp_en         = 1'b1;
    inst_ready     = 1'b1;
    tick(3);

    // 1: streaming from reset, one instruction per cycle.
    reset_n = 1'b1;
    tick(12);
    chk("t1_acc0", lg(0, 0), 32'h0);
    chk("t1_acc1", lg(0, 1), 32'h4);
    chk("t1_acc2", lg(0, 2), 32'h8);
    chk("t1_acc3", lg(0, 3), 32'hC);
    chk("t1_pc0", lg(1, 0), 32'h0);
    chk("t1_pc2", lg(1, 2), 32'h8);
    chk("t1_p4_0", lg(2, 0), 32'h4);
    n0 = log_pc.size();
    tick(8);
    chk("t1_rate", 32'(log_pc.size() - n0), 32'd8);

    // 2: decode stalled, credit limits to four requests; then drain.
    reset_n    = 1'b0;
    inst_ready = 1'b0;
    tick(2);
    clear_logs();
    reset_n = 1'b1;
    tick(8);
    chk("t2_acc_cnt", 32'(log_acc.size()), 32'd4);
    chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t2_acc3", lg(0, 3), 32'hC);
    chk("t2_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick(8);
    chk("t2_pc0", lg(1, 0), 32'h0);
    chk("t2_pc1", lg(1, 1), 32'h4);
    chk("t2_pc2", lg(1, 2), 32'h8);
    chk("t2_pc3", lg(1, 3), 32'hC);
    chk("t2_resume", lg(0, 4), 32'h10);

    // 3: redirect with two buffered and two outstanding requests.
    reset_n    = 1'b0;
    inst_ready = 1'b0;
    tick(2);
    clear_logs();
    reset_n = 1'b1;
    tick(2);
    rsp_en = 1'b0;
    tick(3);
    chk("t3_req_blocked", 32'(imem_req_valid), 32'd0);
    chk("t3_head_pc", inst_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    rsp_en         = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    clear_logs();
    chk("t3_flushed", 32'(inst_valid), 32'd0);
    chk("t3_new_addr", imem_req_addr, 32'h100);
    inst_ready = 1'b1;
    tick(8);
    chk("t3_first_acc", lg(0, 0), 32'h100);
    chk("t3_first_pc", lg(1, 0), 32'h100);
    chk("t3_second_pc", lg(1, 1), 32'h104);

    // 4: memory not ready, request held stable.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    imem_req_ready = 1'b0;
    tick(1);
    redirect_valid = 1'b0;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("t4_hold_addr", imem_req_addr, 32'h200);
      tick(1);
    end
    imem_req_ready = 1'b1;
    tick(1);
    chk("t4_advance", imem_req_addr, 32'h204);

    // 5: redirect to the top word, PC wraps to zero.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick(1);
    redirect_valid = 1'b0;
    clear_logs();
    tick(8);
    chk("t5_acc0", lg(0, 0), 32'hFFFF_FFFC);
    chk("t5_acc1", lg(0, 1), 32'h0);
    chk("t5_pc0", lg(1, 0), 32'hFFFF_FFFC);
    chk("t5_p4_0", lg(2, 0), 32'h0);
    chk("t5_pc1", lg(1, 1), 32'h0);

    // 6: asynchronous reset mid-stream.
    chk("t6_pre_valid", 32'(inst_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_req_drop", 32'(imem_req_valid), 32'd0);
    chk("t6_inst_drop", 32'(inst_valid), 32'd0);
    tick(3);
    clear_logs();
    reset_n = 1'b1;
    tick(6);
    chk("t6_acc0", lg(0, 0), 32'h0);
    chk("t6_acc1", lg(0, 1), 32'h4);
    chk("t6_pc0", lg(1, 0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
